// File: rtl/execute_pkg.sv
// Shared types for the RV32IM execute stage: operation codes, control states
// and forwarding-select encodings.
package execute_pkg;

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,
        OP_SUB   = 5'd1,
        OP_SLL   = 5'd2,
        OP_SLT   = 5'd3,
        OP_SLTU  = 5'd4,
        OP_XOR   = 5'd5,
        OP_SRL   = 5'd6,
        OP_SRA   = 5'd7,
        OP_OR    = 5'd8,
        OP_AND   = 5'd9,
        OP_MUL   = 5'd10,
        OP_MULHU = 5'd11,
        OP_DIV   = 5'd12,
        OP_DIVU  = 5'd13,
        OP_REM   = 5'd14,
        OP_REMU  = 5'd15
    } exec_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIN  = 2'd2
    } ex_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    function automatic logic is_mdu_op(input logic [4:0] o);
        return (o == OP_MUL) || (o == OP_MULHU) || (o == OP_DIV) ||
               (o == OP_DIVU) || (o == OP_REM) || (o == OP_REMU);
    endfunction

endpackage

// File: rtl/execute_unit_muldiv_iter.sv
// Radix-2 iterative multiply / restoring divide engine, one bit per cycle,
// with RISC-V sign and divide-by-zero fixup applied to the final result.
module muldiv_iter
    import execute_pkg::*;
#(
    parameter int DATA_WIDTH = 32
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  kill,
    input  logic [4:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(W);

    exec_op_t           op_reg;
    logic [2*W-1:0]     work_reg;
    logic [2*W-1:0]     work_next;
    logic [W-1:0]       operand_reg;
    logic [W-1:0]       dividend_reg;
    logic               is_div_reg;
    logic               neg_q_reg;
    logic               neg_r_reg;
    logic               div_zero_reg;
    logic               busy_reg;
    logic [CNT_W-1:0]   cnt_reg;

    logic               start_signed;
    logic               start_is_div;
    logic               a_neg;
    logic               b_neg;
    logic [W-1:0]       a_mag;
    logic [W-1:0]       b_mag;

    assign start_signed = (op == OP_DIV) || (op == OP_REM);
    assign start_is_div = (op == OP_DIV) || (op == OP_DIVU) ||
                          (op == OP_REM) || (op == OP_REMU);
    assign a_neg = start_signed && a[W-1];
    assign b_neg = start_signed && b[W-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // Multiply: high half accumulates, low half shifts the multiplier out.
    // Divide: {remainder, quotient} shifts left, dividend bits enter the remainder.
    logic [W:0] mul_sum;
    logic [W:0] div_shifted;
    logic [W:0] div_diff;

    always_comb begin
        mul_sum     = {1'b0, work_reg[2*W-1:W]} +
                      (work_reg[0] ? {1'b0, operand_reg} : {(W+1){1'b0}});
        div_shifted = work_reg[2*W-1:W-1];
        div_diff    = div_shifted - {1'b0, operand_reg};
        work_next   = {mul_sum, work_reg[W-1:1]};
        if (is_div_reg) begin
            if (div_diff[W])
                work_next = {div_shifted[W-1:0], work_reg[W-2:0], 1'b0};
            else
                work_next = {div_diff[W-1:0], work_reg[W-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg       <= OP_MUL;
            work_reg     <= '0;
            operand_reg  <= '0;
            dividend_reg <= '0;
            is_div_reg   <= 1'b0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
            busy_reg     <= 1'b0;
            cnt_reg      <= '0;
        end else if (kill) begin
            busy_reg <= 1'b0;
            cnt_reg  <= '0;
        end else if (start) begin
            op_reg       <= exec_op_t'(op);
            work_reg     <= {{W{1'b0}}, (start_is_div ? a_mag : a)};
            operand_reg  <= start_is_div ? b_mag : b;
            dividend_reg <= a;
            is_div_reg   <= start_is_div;
            neg_q_reg    <= a_neg ^ b_neg;
            neg_r_reg    <= a_neg;
            div_zero_reg <= (b == '0);
            busy_reg     <= 1'b1;
            cnt_reg      <= '0;
        end else if (busy_reg) begin
            work_reg <= work_next;
            cnt_reg  <= cnt_reg + 1'b1;
            if (cnt_reg == CNT_W'(W-1))
                busy_reg <= 1'b0;
        end
    end

    assign busy = busy_reg;
    assign done = busy_reg && (cnt_reg == CNT_W'(W-1));

    logic [W-1:0] quo;
    logic [W-1:0] rem;
    assign quo = work_reg[W-1:0];
    assign rem = work_reg[2*W-1:W];

    // Overflow (most-negative / -1) needs no special case: the magnitude
    // quotient already equals the dividend bit pattern and the remainder is 0.
    always_comb begin
        result = work_reg[W-1:0];
        case (op_reg)
            OP_MULHU:        result = work_reg[2*W-1:W];
            OP_DIV, OP_DIVU: result = div_zero_reg ? {W{1'b1}} : (neg_q_reg ? -quo : quo);
            OP_REM, OP_REMU: result = div_zero_reg ? dividend_reg : (neg_r_reg ? -rem : rem);
            default:         result = work_reg[W-1:0];
        endcase
    end

endmodule

// File: rtl/execute_unit.sv
// RV32IM execute stage: operand forwarding, single-cycle ALU, iterative
// mul/div engine and a registered EX/MEM output slot with valid/ready.
module execute_unit
    import execute_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            op,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic                  alu_src,
    input  logic [1:0]            fwd_a_sel,
    input  logic [1:0]            fwd_b_sel,
    input  logic [DATA_WIDTH-1:0] fwd_mem_data,
    input  logic [DATA_WIDTH-1:0] fwd_wb_data,
    input  logic [4:0]            rd_in,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [DATA_WIDTH-1:0] out_write_data,
    output logic [4:0]            out_rd,
    output logic                  out_eq,
    output logic                  out_lt,
    output logic                  out_ltu,
    output logic                  busy
);
    localparam int W = DATA_WIDTH;

    ex_state_t     state_reg, state_next;
    logic [W-1:0]  a_op, rs2_fwd, b_op, alu_result, mdu_result;
    logic [SHAMT_W-1:0] shamt;
    exec_op_t      op_e;
    logic          flag_eq, flag_lt, flag_ltu;
    logic          slot_free, issue, alu_load, mdu_start, fin_load, mdu_done, mdu_busy;

    logic          out_valid_reg;
    logic [W-1:0]  out_result_reg, out_write_data_reg;
    logic [4:0]    out_rd_reg;
    logic          out_eq_reg, out_lt_reg, out_ltu_reg;
    logic [W-1:0]  pend_wdata_reg;
    logic [4:0]    pend_rd_reg;
    logic          pend_eq_reg, pend_lt_reg, pend_ltu_reg;

    // Reserved select 11 falls back to the register file.
    always_comb begin
        case (fwd_a_sel)
            FWD_MEM: a_op = fwd_mem_data;
            FWD_WB:  a_op = fwd_wb_data;
            default: a_op = rs1_data;
        endcase
        case (fwd_b_sel)
            FWD_MEM: rs2_fwd = fwd_mem_data;
            FWD_WB:  rs2_fwd = fwd_wb_data;
            default: rs2_fwd = rs2_data;
        endcase
    end

    assign b_op     = alu_src ? imm : rs2_fwd;
    assign shamt    = b_op[SHAMT_W-1:0];
    assign op_e     = exec_op_t'(op);
    assign flag_eq  = (a_op == rs2_fwd);
    assign flag_lt  = ($signed(a_op) < $signed(rs2_fwd));
    assign flag_ltu = (a_op < rs2_fwd);

    always_comb begin
        alu_result = a_op + b_op;
        case (op_e)
            OP_SUB:  alu_result = a_op - b_op;
            OP_SLL:  alu_result = a_op << shamt;
            OP_SLT:  alu_result = {{(W-1){1'b0}}, ($signed(a_op) < $signed(b_op))};
            OP_SLTU: alu_result = {{(W-1){1'b0}}, (a_op < b_op)};
            OP_XOR:  alu_result = a_op ^ b_op;
            OP_SRL:  alu_result = a_op >> shamt;
            OP_SRA:  alu_result = $unsigned($signed(a_op) >>> shamt);
            OP_OR:   alu_result = a_op | b_op;
            OP_AND:  alu_result = a_op & b_op;
            default: alu_result = a_op + b_op;
        endcase
    end

    assign slot_free = !out_valid_reg || out_ready;

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        fin_load   = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = slot_free && !flush;
                if (in_valid && in_ready && is_mdu_op(op))
                    state_next = ITER;
            end
            ITER: if (mdu_done) state_next = FIN;
            FIN: begin
                fin_load = slot_free && !flush;
                if (slot_free) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    assign issue     = in_valid && in_ready;
    assign alu_load  = issue && !is_mdu_op(op);
    assign mdu_start = issue && is_mdu_op(op);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    muldiv_iter #(.DATA_WIDTH(W)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mdu_start),
        .kill   (flush),
        .op     (op),
        .a      (a_op),
        .b      (b_op),
        .busy   (mdu_busy),
        .done   (mdu_done),
        .result (mdu_result)
    );

    // Tags and branch flags of an M op are held here until its result lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_wdata_reg <= '0;
            pend_rd_reg    <= '0;
            pend_eq_reg    <= 1'b0;
            pend_lt_reg    <= 1'b0;
            pend_ltu_reg   <= 1'b0;
        end else if (mdu_start) begin
            pend_wdata_reg <= rs2_fwd;
            pend_rd_reg    <= rd_in;
            pend_eq_reg    <= flag_eq;
            pend_lt_reg    <= flag_lt;
            pend_ltu_reg   <= flag_ltu;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg      <= 1'b0;
            out_result_reg     <= '0;
            out_write_data_reg <= '0;
            out_rd_reg         <= '0;
            out_eq_reg         <= 1'b0;
            out_lt_reg         <= 1'b0;
            out_ltu_reg        <= 1'b0;
        end else begin
            if (flush)
                out_valid_reg <= 1'b0;
            else if (alu_load || fin_load)
                out_valid_reg <= 1'b1;
            else if (out_ready)
                out_valid_reg <= 1'b0;

            if (alu_load) begin
                out_result_reg     <= alu_result;
                out_write_data_reg <= rs2_fwd;
                out_rd_reg         <= rd_in;
                out_eq_reg         <= flag_eq;
                out_lt_reg         <= flag_lt;
                out_ltu_reg        <= flag_ltu;
            end else if (fin_load) begin
                out_result_reg     <= mdu_result;
                out_write_data_reg <= pend_wdata_reg;
                out_rd_reg         <= pend_rd_reg;
                out_eq_reg         <= pend_eq_reg;
                out_lt_reg         <= pend_lt_reg;
                out_ltu_reg        <= pend_ltu_reg;
            end
        end
    end

    assign out_valid      = out_valid_reg;
    assign out_result     = out_result_reg;
    assign out_write_data = out_write_data_reg;
    assign out_rd         = out_rd_reg;
    assign out_eq         = out_eq_reg;
    assign out_lt         = out_lt_reg;
    assign out_ltu        = out_ltu_reg;
    assign busy           = mdu_busy;

endmodule

// File: tb/tb_execute_unit.sv
// Directed self-checking bench for execute_unit: ALU, forwarding, mul/div
// corner cases, backpressure, flush and asynchronous reset.
module tb_execute_unit;
    import execute_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [31:0] rs1_data, rs2_data, imm;
    logic        alu_src;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [31:0] fwd_mem_data, fwd_wb_data;
    logic [4:0]  rd_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result, out_write_data;
    logic [4:0]  out_rd;
    logic        out_eq, out_lt, out_ltu;
    logic        busy;

    int checks = 0;
    int errors = 0;

    execute_unit #(.DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .op             (op),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .imm            (imm),
        .alu_src        (alu_src),
        .fwd_a_sel      (fwd_a_sel),
        .fwd_b_sel      (fwd_b_sel),
        .fwd_mem_data   (fwd_mem_data),
        .fwd_wb_data    (fwd_wb_data),
        .rd_in          (rd_in),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_write_data (out_write_data),
        .out_rd         (out_rd),
        .out_eq         (out_eq),
        .out_lt         (out_lt),
        .out_ltu        (out_ltu),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            $display("check %-22s observed %h expected %h ok", tag, obs, exp);
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [4:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
        op        = o;
        rs1_data  = a;
        rs2_data  = b;
        rd_in     = rd;
        alu_src   = 1'b0;
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        in_valid  = 1'b1;
    endtask

    task automatic run_mdu(input string tag, input logic [4:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        int   lat;
        logic rdy_seen;
        set_op(o, a, b, 5'd9);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        lat      = 0;
        rdy_seen = 1'b0;
        check({tag, " busy"}, 32'(busy), 32'd1);
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_seen = 1'b1;
            tick();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd33);
        check({tag, " result"}, out_result, exp);
        check({tag, " rd"}, 32'(out_rd), 32'd9);
        check({tag, " ready low"}, 32'(rdy_seen), 32'd0);
        tick();
    endtask

    initial begin
        int   seen;
        rst_n = 1'b0; in_valid = 1'b0; op = '0; rs1_data = '0; rs2_data = '0;
        imm = '0; alu_src = 1'b0; fwd_a_sel = '0; fwd_b_sel = '0;
        fwd_mem_data = '0; fwd_wb_data = '0; rd_in = '0; flush = 1'b0; out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset out_result", out_result, 32'd0);
        check("reset out_rd", 32'(out_rd), 32'd0);
        check("reset flags", {29'd0, out_eq, out_lt, out_ltu}, 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);

        // ADD wrap through immediate
        set_op(OP_ADD, 32'h7FFF_FFFF, 32'h0, 5'd3);
        alu_src = 1'b1; imm = 32'd1;
        tick();
        in_valid = 1'b0;
        check("add valid", 32'(out_valid), 32'd1);
        check("add result", out_result, 32'h8000_0000);
        check("add rd", 32'(out_rd), 32'd3);
        check("add flags", {29'd0, out_eq, out_lt, out_ltu}, 32'd0);
        tick();
        check("add consumed", 32'(out_valid), 32'd0);

        // SRA then SLTU back-to-back
        set_op(OP_SRA, 32'h8000_0000, 32'h0, 5'd4);
        alu_src = 1'b1; imm = 32'h21;
        tick();
        check("sra result", out_result, 32'hC000_0000);
        set_op(OP_SLTU, 32'd1, 32'd2, 5'd5);
        tick();
        in_valid = 1'b0;
        check("sltu result", out_result, 32'd1);
        check("sltu ltu", 32'(out_ltu), 32'd1);
        check("sltu valid", 32'(out_valid), 32'd1);
        check("sltu wdata", out_write_data, 32'd2);
        tick();
        check("sltu consumed", 32'(out_valid), 32'd0);

        // Forwarding
        set_op(OP_SUB, 32'd5, 32'd9, 5'd6);
        fwd_a_sel = 2'b01; fwd_mem_data = 32'd9;
        tick();
        check("fwd sub result", out_result, 32'd0);
        check("fwd sub eq/lt", {30'd0, out_eq, out_lt}, 32'd2);
        set_op(OP_XOR, 32'd0, 32'h0F, 5'd6);
        fwd_a_sel = 2'b10; fwd_wb_data = 32'hFF; fwd_b_sel = 2'b11; fwd_mem_data = 32'h77;
        tick();
        check("fwd wb/rsvd xor", out_result, 32'hF0);
        set_op(5'd31, 32'd2, 32'd3, 5'd6);
        tick();
        in_valid = 1'b0;
        check("undef op as add", out_result, 32'd5);
        tick();

        // Mul/div corner cases
        run_mdu("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_mdu("rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        run_mdu("divu by0", OP_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF);
        run_mdu("remu by0", OP_REMU, 32'd7, 32'd0, 32'd7);
        run_mdu("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_mdu("mul", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1);
        run_mdu("div neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_mdu("rem neg", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);

        // Backpressure
        out_ready = 1'b0;
        set_op(OP_ADD, 32'd1, 32'd1, 5'd1);
        #1 check("bp ready first", 32'(in_ready), 32'd1);
        tick();
        set_op(OP_ADD, 32'd10, 32'd10, 5'd2);
        #1 check("bp ready blocked", 32'(in_ready), 32'd0);
        repeat (3) tick();
        check("bp held valid", 32'(out_valid), 32'd1);
        check("bp held result", out_result, 32'd2);
        check("bp held rd", 32'(out_rd), 32'd1);
        out_ready = 1'b1;
        #1 check("bp ready release", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp second valid", 32'(out_valid), 32'd1);
        check("bp second result", out_result, 32'd20);
        check("bp second rd", 32'(out_rd), 32'd2);
        tick();
        check("bp drained", 32'(out_valid), 32'd0);

        // Flush mid-DIV at iteration 10
        set_op(OP_DIV, 32'd100, 32'd3, 5'd8);
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush busy", 32'(busy), 32'd0);
        check("flush valid", 32'(out_valid), 32'd0);
        #1 check("flush ready", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (40) begin
            tick();
            if (out_valid) seen++;
        end
        check("flush no result", 32'(seen), 32'd0);
        flush = 1'b1;
        set_op(OP_ADD, 32'd1, 32'd1, 5'd1);
        #1 check("flush drop ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush drop issue", 32'(out_valid), 32'd0);
        set_op(OP_ADD, 32'd3, 32'd4, 5'd10);
        tick();
        in_valid = 1'b0;
        check("post-flush add", out_result, 32'd7);
        check("post-flush valid", 32'(out_valid), 32'd1);
        tick();

        // Asynchronous reset mid-MUL
        set_op(OP_MUL, 32'd6, 32'd7, 5'd11);
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst valid", 32'(out_valid), 32'd0);
        check("rst result", out_result, 32'd0);
        check("rst rd", 32'(out_rd), 32'd0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            tick();
            if (out_valid) seen++;
        end
        check("rst no result", 32'(seen), 32'd0);
        check("rst ready", 32'(in_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
